lambda_mem_arbiter: RTL
=======================

Name: lambda_mem_arbiter

Overview:
- Owns the single lambda SRAM: one write and one read per cycle are impossible, so this block shares the SRAM between the check-node update path (writer) and the variable-node fetch path (reader).
- Clears the whole memory after reset and on request, and returns read data with a valid strobe.
- Sits between the LDPC node processors and sram_lambda; drives every sram_lambda input and takes its o_rdata.

Parameters:
WIDTH, 8, lambda word width in bits (matches SRAM WIDTH)
ROW_NUMBER, 1024, SRAM depth in words; legal addresses 0..ROW_NUMBER-1
ADDR_W, 20, address width (matches SRAM address ports)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_clear  in  1  one-cycle pulse; (re)starts the zero-fill sweep
o_busy  out  1  high while the sweep runs
i_wr_req  in  1  writer request
i_wr_addr  in  ADDR_W  write address
i_wr_data  in  WIDTH  write data
o_wr_gnt  out  1  write accepted this cycle
i_rd_req  in  1  reader request
i_rd_addr  in  ADDR_W  read address
o_rd_gnt  out  1  read accepted this cycle
o_rd_valid  out  1  o_rd_data valid this cycle
o_rd_data  out  WIDTH  read data
o_err  out  1  sticky: an out-of-range address was accepted
o_sram_wen  out  1  to SRAM i_wen
o_sram_waddr  out  ADDR_W  to SRAM i_waddr
o_sram_raddr  out  ADDR_W  to SRAM i_raddr
o_sram_wdata  out  WIDTH  to SRAM i_wdata
i_sram_rdata  in  WIDTH  from SRAM o_rdata

Behaviour:
- Reset (async, rst_n low):
  - state=INIT, sweep count=0.
  - o_sram_wen/waddr/raddr/wdata=0.
  - o_rd_valid=0, o_err=0.
  - Round-robin pointer = "read last", so the writer wins the first tie.
- States:
  - INIT:
    - Each cycle, register a write of 0 to address count; count++.
    - o_busy=1; o_wr_gnt=o_rd_gnt=0.
    - After address ROW_NUMBER-1 is issued, go to SERVE. The sweep takes exactly ROW_NUMBER cycles.
  - SERVE:
    - o_busy=0; arbitrate one requester per cycle.
    - i_clear in SERVE: go to INIT with count=0.
    - i_clear in INIT: restart count at 0.
- Arbitration (SERVE only):
  - Grants are combinational from requests and the pointer.
  - Only one requester active: it is granted, so full throughput is 1 access/cycle.
  - Both active: grant the side not granted last; the pointer updates only on a grant.
  - No request: SRAM outputs register wen=0 and raddr is held (idle read is harmless).
- SRAM-side outputs are registered. For a grant in cycle t:
  - Write: o_sram_wen=1 with addr/data from edge t+1; the SRAM writes at edge t+2.
  - Read: o_sram_wen=0 and raddr set at edge t+1; the SRAM samples at edge t+2.
  - o_rd_valid=1 and o_rd_data=i_sram_rdata in cycle t+2. Read latency is fixed at 2 cycles; valid is a one-cycle pulse per grant.
- o_rd_data is 0 when o_rd_valid=0.
- Hazard: a read granted any cycle after a write to the same address returns the new data. Ordering is by grant cycle; no forwarding is needed.
- Out-of-range address (>= ROW_NUMBER):
  - The request is still granted and o_err is set (stays set until reset).
  - A write is dropped (wen stays 0).
  - A read produces o_rd_valid with data 0.
- i_clear or sweep with reads in flight: reads already granted still deliver o_rd_valid on schedule. Sweep writes do not disturb a read in flight, because SRAM o_rdata is held while wen=1.
- Width: count is ADDR_W bits. ROW_NUMBER must satisfy ROW_NUMBER <= 2**ADDR_W; flag this with a static check.

Decomposition:
- Shared package/include: state encoding (INIT, SERVE), ADDR_W default, the read latency constant (2).
- One natural sub-module: rr_arb2, a two-requester round-robin arbiter with the pointer register, reset-to-"read last".

Test Plan:
- Sweep after reset: release rst_n with ROW_NUMBER=16 -> o_busy high exactly 16 cycles, addresses 0..15 written with 0; a read of addr 5 afterwards returns 0 at t+2.
- Single requesters: write 0xA5 to addr 3, then read addr 3 the next cycle -> o_rd_gnt high, o_rd_valid high 2 cycles after the read grant, o_rd_data=0xA5.
- Contention: both requesters held high for 6 cycles after the sweep -> grants alternate W,R,W,R,W,R; three o_rd_valid pulses, each 2 cycles after its grant.
- i_clear mid-traffic: a read granted in cycle t and i_clear in cycle t+1 -> o_rd_valid still at t+2 with the old data; sweep of ROW_NUMBER cycles; grants 0 throughout the sweep.
- Out-of-range: write to addr 16 with ROW_NUMBER=16 -> granted, o_err=1, no SRAM write; read of addr 16 -> o_rd_valid with data 0; o_err stays 1 until rst_n.
- Async reset mid-read: assert rst_n low between grant and valid -> outputs go to their reset values immediately, no o_rd_valid afterwards, sweep restarts.

Source files
------------

// File: rtl/lambda_mem_arbiter_pkg.sv
// Shared definitions for the lambda SRAM arbiter: controller states,
// default address width and the fixed read-return latency.
package lambda_mem_arbiter_pkg;

  // INIT runs the zero-fill sweep, SERVE arbitrates node-processor traffic
  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_SERVE = 1'b1
  } arb_state_t;

  localparam int ADDR_W_DEF = 20;

  // Cycles from a read grant to its o_rd_valid pulse
  localparam int RD_LATENCY = 2;

endpackage

// File: rtl/lambda_mem_arbiter_if.sv
// Node-processor side of the lambda SRAM arbiter: clear/busy control,
// writer and reader request/grant channels, read return and error flag.
interface lambda_mem_arbiter_if
  import lambda_mem_arbiter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = ADDR_W_DEF
);
  logic              i_clear;
  logic              o_busy;
  logic              i_wr_req;
  logic [ADDR_W-1:0] i_wr_addr;
  logic [WIDTH-1:0]  i_wr_data;
  logic              o_wr_gnt;
  logic              i_rd_req;
  logic [ADDR_W-1:0] i_rd_addr;
  logic              o_rd_gnt;
  logic              o_rd_valid;
  logic [WIDTH-1:0]  o_rd_data;
  logic              o_err;

  // Node processors drive requests and observe grants/returns
  modport master (
    output i_clear, i_wr_req, i_wr_addr, i_wr_data, i_rd_req, i_rd_addr,
    input  o_busy, o_wr_gnt, o_rd_gnt, o_rd_valid, o_rd_data, o_err
  );

  // The arbiter consumes requests and produces grants/returns
  modport slave (
    input  i_clear, i_wr_req, i_wr_addr, i_wr_data, i_rd_req, i_rd_addr,
    output o_busy, o_wr_gnt, o_rd_gnt, o_rd_valid, o_rd_data, o_err
  );
endinterface

// File: rtl/lambda_mem_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter (writer vs reader). Grants are
// combinational; the pointer remembers which side was granted last and
// resets to "read last" so the writer wins the first tie.
module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic wr_req,
  input  logic rd_req,
  output logic wr_gnt,
  output logic rd_gnt
);

  logic last_rd_r;

  // Pick one requester; on a tie favour the side not granted last
  always_comb begin
    wr_gnt = 1'b0;
    rd_gnt = 1'b0;
    if (!en) begin
      wr_gnt = 1'b0;
      rd_gnt = 1'b0;
    end else if (wr_req && rd_req) begin
      wr_gnt = last_rd_r;
      rd_gnt = ~last_rd_r;
    end else begin
      wr_gnt = wr_req;
      rd_gnt = rd_req;
    end
  end

  // Pointer moves only when a grant is actually given
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_rd_r <= 1'b1;
    end else if (wr_gnt) begin
      last_rd_r <= 1'b0;
    end else if (rd_gnt) begin
      last_rd_r <= 1'b1;
    end else begin
      last_rd_r <= last_rd_r;
    end
  end

endmodule

// File: rtl/lambda_mem_arbiter.sv
// Owner of the single-port lambda SRAM: zero-fills it after reset or on
// i_clear, then shares it between the check-node writer and the
// variable-node reader one access per cycle. SRAM-side outputs are
// registered; read data returns a fixed RD_LATENCY cycles after the grant.
module lambda_mem_arbiter
  import lambda_mem_arbiter_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int ROW_NUMBER = 1024,
  parameter int ADDR_W     = ADDR_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  lambda_mem_arbiter_if.slave bus,
  output logic                o_sram_wen,
  output logic [ADDR_W-1:0]   o_sram_waddr,
  output logic [ADDR_W-1:0]   o_sram_raddr,
  output logic [WIDTH-1:0]    o_sram_wdata,
  input  logic [WIDTH-1:0]    i_sram_rdata
);

  localparam logic [ADDR_W:0]   ROW_LIM   = (ADDR_W+1)'(ROW_NUMBER);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROW_NUMBER - 1);

  // The sweep counter is ADDR_W bits wide, so the depth must fit in it
  if (ROW_NUMBER < 1 || longint'(ROW_NUMBER) > (longint'(1) << ADDR_W)) begin : g_row_check
    $error("lambda_mem_arbiter: ROW_NUMBER must be 1..2**ADDR_W");
  end

  arb_state_t        state_r, state_n;
  logic [ADDR_W-1:0] count_r, count_n;
  logic              wen_n;
  logic [ADDR_W-1:0] waddr_n, raddr_n;
  logic [WIDTH-1:0]  wdata_n;
  logic              err_r, err_n;
  logic              arb_en_s, wr_gnt_s, rd_gnt_s;
  logic              wr_oor_s, rd_oor_s;
  logic              rd_issue_s, rd_zero_s;
  logic [RD_LATENCY-1:0] rd_vld_pipe_r, rd_zero_pipe_r;

  assign arb_en_s = (state_r == ST_SERVE) && !bus.i_clear;
  assign wr_oor_s = {1'b0, bus.i_wr_addr} >= ROW_LIM;
  assign rd_oor_s = {1'b0, bus.i_rd_addr} >= ROW_LIM;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (arb_en_s),
    .wr_req (bus.i_wr_req),
    .rd_req (bus.i_rd_req),
    .wr_gnt (wr_gnt_s),
    .rd_gnt (rd_gnt_s)
  );

  assign bus.o_wr_gnt   = wr_gnt_s;
  assign bus.o_rd_gnt   = rd_gnt_s;
  assign bus.o_busy     = (state_r == ST_INIT);
  assign bus.o_err      = err_r;
  assign bus.o_rd_valid = rd_vld_pipe_r[RD_LATENCY-1];

  // Next state and next SRAM command: sweep write in INIT, granted access in SERVE
  always_comb begin
    state_n    = state_r;
    count_n    = count_r;
    wen_n      = 1'b0;
    waddr_n    = o_sram_waddr;
    wdata_n    = o_sram_wdata;
    raddr_n    = o_sram_raddr;
    rd_issue_s = 1'b0;
    rd_zero_s  = 1'b0;
    err_n      = err_r;
    case (state_r)
      ST_INIT: begin
        if (bus.i_clear) begin
          count_n = '0;
        end else begin
          wen_n   = 1'b1;
          waddr_n = count_r;
          wdata_n = '0;
          if (count_r == LAST_ADDR) begin
            state_n = ST_SERVE;
            count_n = '0;
          end else begin
            count_n = count_r + 1'b1;
          end
        end
      end
      ST_SERVE: begin
        if (bus.i_clear) begin
          state_n = ST_INIT;
          count_n = '0;
        end else if (wr_gnt_s) begin
          if (wr_oor_s) begin
            err_n = 1'b1;
          end else begin
            wen_n   = 1'b1;
            waddr_n = bus.i_wr_addr;
            wdata_n = bus.i_wr_data;
          end
        end else if (rd_gnt_s) begin
          rd_issue_s = 1'b1;
          if (rd_oor_s) begin
            rd_zero_s = 1'b1;
            err_n     = 1'b1;
          end else begin
            raddr_n = bus.i_rd_addr;
          end
        end else begin
          wen_n = 1'b0;
        end
      end
      default: begin
        state_n = ST_INIT;
        count_n = '0;
      end
    endcase
  end

  // State, SRAM command registers, sticky error and read-return pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_INIT;
      count_r        <= '0;
      o_sram_wen     <= 1'b0;
      o_sram_waddr   <= '0;
      o_sram_raddr   <= '0;
      o_sram_wdata   <= '0;
      err_r          <= 1'b0;
      rd_vld_pipe_r  <= '0;
      rd_zero_pipe_r <= '0;
    end else begin
      state_r        <= state_n;
      count_r        <= count_n;
      o_sram_wen     <= wen_n;
      o_sram_waddr   <= waddr_n;
      o_sram_raddr   <= raddr_n;
      o_sram_wdata   <= wdata_n;
      err_r          <= err_n;
      rd_vld_pipe_r  <= {rd_vld_pipe_r[RD_LATENCY-2:0], rd_issue_s};
      rd_zero_pipe_r <= {rd_zero_pipe_r[RD_LATENCY-2:0], rd_zero_s};
    end
  end

  // Read data passes the SRAM output through only on a valid, in-range return
  always_comb begin
    bus.o_rd_data = '0;
    if (rd_vld_pipe_r[RD_LATENCY-1] && !rd_zero_pipe_r[RD_LATENCY-1]) begin
      bus.o_rd_data = i_sram_rdata;
    end else begin
      bus.o_rd_data = '0;
    end
  end

endmodule
